// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: default widths, the layout of a
// stage record, and the stage-advance action encoding.
package branch_resolver_pkg;

    // XLEN default matches the predictor's history/BTB address width.
    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 32;

    // A stage record is packed as {valid, pc, pred}, MSB first.
    function automatic int rec_w(input int xlen);
        return 1 + 2 * xlen;
    endfunction

    function automatic int rec_valid_bit(input int xlen);
        return 2 * xlen;
    endfunction

    // What the two pipeline records do at the coming clock edge.
    typedef enum logic [1:0] {
        ADV_SHIFT = 2'd0,
        ADV_STALL = 2'd1,
        ADV_FLUSH = 2'd2
    } stage_adv_e;

endpackage

// File: rtl/branch_resolver_pred_stage_reg.sv
// One pipeline record register {valid, pc, pred}.
// Clear drops only the valid bit; hold keeps the record; load captures input.
module pred_stage_reg
    import branch_resolver_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_hold,
    input  logic            i_clear,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pred,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pred
);

    localparam int RW = rec_w(XLEN);
    localparam int VB = rec_valid_bit(XLEN);

    logic [RW-1:0] r_rec;

    // record update: clear beats hold, hold beats load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rec <= '0;
        end else if (i_clear) begin
            r_rec[VB] <= 1'b0;
        end else if (i_hold) begin
            r_rec <= r_rec;
        end else if (i_load) begin
            r_rec <= {i_valid, i_pc, i_pred};
        end
    end

    assign o_valid = r_rec[VB];
    assign o_pc    = r_rec[2*XLEN-1:XLEN];
    assign o_pred  = r_rec[XLEN-1:0];

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: carries each fetched PC and its prediction through ID and
// EX, flags a mispredict at EX (same-cycle flush/redirect), emits a registered
// predictor update one cycle later and keeps saturating statistics.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_valid,
    input  logic [XLEN-1:0]  i_if_pc,
    input  logic [XLEN-1:0]  i_if_predicted_pc,
    input  logic             i_id_stall,
    input  logic             i_ex_is_ctrl,
    input  logic [XLEN-1:0]  i_ex_actual_next_pc,
    output logic             o_flush,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_update_pred,
    output logic [XLEN-1:0]  o_branch_inst_address,
    output logic [XLEN-1:0]  o_resolved_next_pc,
    output logic             o_predictor_wrong,
    output logic [CNT_W-1:0] o_ctrl_count,
    output logic [CNT_W-1:0] o_mispredict_count
);

    logic            w_id_valid;
    logic [XLEN-1:0] w_id_pc;
    logic [XLEN-1:0] w_id_pred;
    logic            w_ex_valid;
    logic [XLEN-1:0] w_ex_pc;
    logic [XLEN-1:0] w_ex_pred;
    logic            w_wrong;
    logic            w_ctrl_evt;
    logic            w_upd_fire;
    stage_adv_e      w_adv;

    logic             r_update_pred;
    logic [XLEN-1:0]  r_branch_inst_address;
    logic [XLEN-1:0]  r_resolved_next_pc;
    logic             r_predictor_wrong;
    logic [CNT_W-1:0] r_ctrl_count;
    logic [CNT_W-1:0] r_mispredict_count;

    // Full-width compare; EX inputs are meaningless without a valid record.
    assign w_wrong    = w_ex_valid & (w_ex_pred != i_ex_actual_next_pc);
    assign w_ctrl_evt = w_ex_valid & i_ex_is_ctrl;
    // A non-control instruction only trains when a BTB alias mispredicted it.
    assign w_upd_fire = w_ex_valid & (i_ex_is_ctrl | w_wrong);

    // choose the stage-advance action; a mispredict outranks a load-use stall
    always_comb begin
        w_adv = ADV_SHIFT;
        if (w_wrong) begin
            w_adv = ADV_FLUSH;
        end else if (i_id_stall) begin
            w_adv = ADV_STALL;
        end
    end

    pred_stage_reg #(.XLEN(XLEN)) u_id_stage (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (1'b1),
        .i_hold  (w_adv == ADV_STALL),
        .i_clear (w_adv == ADV_FLUSH),
        .i_valid (i_if_valid),
        .i_pc    (i_if_pc),
        .i_pred  (i_if_predicted_pc),
        .o_valid (w_id_valid),
        .o_pc    (w_id_pc),
        .o_pred  (w_id_pred)
    );

    // EX takes a bubble on both flush and stall.
    pred_stage_reg #(.XLEN(XLEN)) u_ex_stage (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (1'b1),
        .i_hold  (1'b0),
        .i_clear (w_adv != ADV_SHIFT),
        .i_valid (w_id_valid),
        .i_pc    (w_id_pc),
        .i_pred  (w_id_pred),
        .o_valid (w_ex_valid),
        .o_pc    (w_ex_pc),
        .o_pred  (w_ex_pred)
    );

    // predictor update register: one pulse per resolved instruction, fields hold otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_update_pred         <= 1'b0;
            r_branch_inst_address <= '0;
            r_resolved_next_pc    <= '0;
            r_predictor_wrong     <= 1'b0;
        end else begin
            r_update_pred <= w_upd_fire;
            if (w_upd_fire) begin
                r_branch_inst_address <= w_ex_pc;
                r_resolved_next_pc    <= i_ex_actual_next_pc;
                r_predictor_wrong     <= w_wrong;
            end
        end
    end

    // saturating statistics counters; they stick at all-ones instead of wrapping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl_count       <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_ctrl_evt && (r_ctrl_count != {CNT_W{1'b1}})) begin
                r_ctrl_count <= r_ctrl_count + CNT_W'(1);
            end
            if (w_wrong && (r_mispredict_count != {CNT_W{1'b1}})) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    assign o_flush               = w_wrong;
    assign o_redirect_pc         = w_wrong ? i_ex_actual_next_pc : '0;
    assign o_update_pred         = r_update_pred;
    assign o_branch_inst_address = r_branch_inst_address;
    assign o_resolved_next_pc    = r_resolved_next_pc;
    assign o_predictor_wrong     = r_predictor_wrong;
    assign o_ctrl_count          = r_ctrl_count;
    assign o_mispredict_count    = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver. A second instance with 2-bit counters
// shares the stimulus so saturation is reached by real events.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pred;
    logic        id_stall;
    logic        ex_is_ctrl;
    logic [31:0] ex_actual;

    logic        flush, upd, pwrong;
    logic [31:0] redirect, bia, rnp, ctrl_cnt, mis_cnt;

    logic        s_flush, s_upd, s_pwrong;
    logic [31:0] s_redirect, s_bia, s_rnp;
    logic [1:0]  s_ctrl_cnt, s_mis_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolver #(.XLEN(32), .CNT_W(32)) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_if_valid            (if_valid),
        .i_if_pc               (if_pc),
        .i_if_predicted_pc     (if_pred),
        .i_id_stall            (id_stall),
        .i_ex_is_ctrl          (ex_is_ctrl),
        .i_ex_actual_next_pc   (ex_actual),
        .o_flush               (flush),
        .o_redirect_pc         (redirect),
        .o_update_pred         (upd),
        .o_branch_inst_address (bia),
        .o_resolved_next_pc    (rnp),
        .o_predictor_wrong     (pwrong),
        .o_ctrl_count          (ctrl_cnt),
        .o_mispredict_count    (mis_cnt)
    );

    branch_resolver #(.XLEN(32), .CNT_W(2)) dut_sat (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_if_valid            (if_valid),
        .i_if_pc               (if_pc),
        .i_if_predicted_pc     (if_pred),
        .i_id_stall            (id_stall),
        .i_ex_is_ctrl          (ex_is_ctrl),
        .i_ex_actual_next_pc   (ex_actual),
        .o_flush               (s_flush),
        .o_redirect_pc         (s_redirect),
        .o_update_pred         (s_upd),
        .o_branch_inst_address (s_bia),
        .o_resolved_next_pc    (s_rnp),
        .o_predictor_wrong     (s_pwrong),
        .o_ctrl_count          (s_ctrl_cnt),
        .o_mispredict_count    (s_mis_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] pred);
        if_valid = 1'b1;
        if_pc    = pc;
        if_pred  = pred;
    endtask

    task automatic ex_in(input logic ctrl, input logic [31:0] actual);
        ex_is_ctrl = ctrl;
        ex_actual  = actual;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_pred = '0;
        id_stall = 1'b0; ex_is_ctrl = 1'b0; ex_actual = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_flush",    64'(flush),    64'(0));
        check_val("rst_redirect", 64'(redirect), 64'(0));
        check_val("rst_upd",      64'(upd),      64'(0));
        check_val("rst_ctrl",     64'(ctrl_cnt), 64'(0));
        check_val("rst_mis",      64'(mis_cnt),  64'(0));
        rst = 1'b0;

        // correct not-taken
        fetch(32'h100, 32'h104); step();
        if_valid = 1'b0; step();
        ex_in(1'b1, 32'h104); #1;
        check_val("nt_flush",    64'(flush),    64'(0));
        check_val("nt_redirect", 64'(redirect), 64'(0));
        step();
        check_val("nt_upd",   64'(upd),      64'(1));
        check_val("nt_bia",   64'(bia),      64'h100);
        check_val("nt_rnp",   64'(rnp),      64'h104);
        check_val("nt_wrong", 64'(pwrong),   64'(0));
        check_val("nt_ctrl",  64'(ctrl_cnt), 64'(1));
        step();
        check_val("nt_pulse",    64'(upd), 64'(0));
        check_val("nt_bia_hold", 64'(bia), 64'h100);

        // taken mispredict with a wrong-path fetch in the flush cycle
        fetch(32'h200, 32'h204); step();
        fetch(32'h204, 32'h208); step();
        ex_in(1'b1, 32'h180); fetch(32'h500, 32'h504); #1;
        check_val("mp_flush",    64'(flush),    64'(1));
        check_val("mp_redirect", 64'(redirect), 64'h180);
        step();
        if_valid = 1'b0;
        check_val("mp_upd",   64'(upd),      64'(1));
        check_val("mp_wrong", 64'(pwrong),   64'(1));
        check_val("mp_bia",   64'(bia),      64'h200);
        check_val("mp_rnp",   64'(rnp),      64'h180);
        check_val("mp_mis",   64'(mis_cnt),  64'(1));
        check_val("mp_ctrl",  64'(ctrl_cnt), 64'(2));
        ex_in(1'b1, 32'hDEAD0000); #1;
        check_val("mp_ex_clr", 64'(flush), 64'(0));
        step();
        check_val("mp_no_upd1", 64'(upd), 64'(0));
        check_val("mp_id_clr",  64'(flush), 64'(0));
        step();
        check_val("mp_no_upd2", 64'(upd),     64'(0));
        check_val("mp_mis_hold", 64'(mis_cnt), 64'(1));

        // load-use stall: two bubbles then a single resolution
        fetch(32'h300, 32'h304); step();
        if_valid = 1'b0; id_stall = 1'b1; ex_in(1'b1, 32'h999); #1;
        check_val("st_flush_b", 64'(flush), 64'(0));
        step();
        check_val("st_upd_b1",  64'(upd),   64'(0));
        check_val("st_flush_c", 64'(flush), 64'(0));
        step();
        check_val("st_upd_b2",  64'(upd),   64'(0));
        id_stall = 1'b0; #1;
        check_val("st_flush_d", 64'(flush), 64'(0));
        step();
        check_val("st_upd_d", 64'(upd), 64'(0));
        ex_in(1'b1, 32'h304); #1;
        check_val("st_flush_e", 64'(flush), 64'(0));
        step();
        check_val("st_upd",  64'(upd),      64'(1));
        check_val("st_bia",  64'(bia),      64'h300);
        check_val("st_ctrl", 64'(ctrl_cnt), 64'(3));
        step();
        check_val("st_once", 64'(upd), 64'(0));

        // mispredict together with a stall: flush wins
        fetch(32'h600, 32'h604); step();
        fetch(32'h604, 32'h608); step();
        if_valid = 1'b0; id_stall = 1'b1; ex_in(1'b1, 32'h700); #1;
        check_val("fs_flush",    64'(flush),    64'(1));
        check_val("fs_redirect", 64'(redirect), 64'h700);
        step();
        id_stall = 1'b0;
        check_val("fs_upd",  64'(upd),      64'(1));
        check_val("fs_bia",  64'(bia),      64'h600);
        check_val("fs_mis",  64'(mis_cnt),  64'(2));
        check_val("fs_ctrl", 64'(ctrl_cnt), 64'(4));
        ex_in(1'b1, 32'h999); #1;
        check_val("fs_ex_clr", 64'(flush), 64'(0));
        step();
        check_val("fs_no_upd1", 64'(upd), 64'(0));
        check_val("fs_id_clr",  64'(flush), 64'(0));
        step();
        check_val("fs_no_upd2", 64'(upd), 64'(0));

        // BTB alias on a non-control instruction
        fetch(32'h400, 32'h800); step();
        if_valid = 1'b0; step();
        ex_in(1'b0, 32'h404); #1;
        check_val("al_flush",    64'(flush),    64'(1));
        check_val("al_redirect", 64'(redirect), 64'h404);
        step();
        check_val("al_upd",   64'(upd),      64'(1));
        check_val("al_wrong", 64'(pwrong),   64'(1));
        check_val("al_bia",   64'(bia),      64'h400);
        check_val("al_rnp",   64'(rnp),      64'h404);
        check_val("al_ctrl",  64'(ctrl_cnt), 64'(4));
        check_val("al_mis",   64'(mis_cnt),  64'(3));

        // back-to-back correct predictions across the top of the address space
        fetch(32'hFFFF_FFF8, 32'hFFFF_FFFC); step();
        fetch(32'hFFFF_FFFC, 32'h0000_0000); step();
        if_valid = 1'b0; ex_in(1'b1, 32'hFFFF_FFFC); #1;
        check_val("bb_flush1", 64'(flush), 64'(0));
        step();
        check_val("bb_upd1", 64'(upd), 64'(1));
        check_val("bb_bia1", 64'(bia), 64'hFFFF_FFF8);
        ex_in(1'b1, 32'h0); #1;
        check_val("bb_flush2", 64'(flush), 64'(0));
        step();
        check_val("bb_upd2",  64'(upd),      64'(1));
        check_val("bb_bia2",  64'(bia),      64'hFFFF_FFFC);
        check_val("bb_rnp2",  64'(rnp),      64'h0);
        check_val("bb_wrong", 64'(pwrong),   64'(0));
        check_val("bb_ctrl",  64'(ctrl_cnt), 64'(6));

        // one more mispredict pushes the narrow counters past their limit
        fetch(32'h900, 32'h904); step();
        if_valid = 1'b0; step();
        ex_in(1'b1, 32'h100); #1;
        check_val("x_redirect", 64'(redirect), 64'h100);
        step();
        check_val("x_mis",      64'(mis_cnt),    64'(4));
        check_val("x_ctrl",     64'(ctrl_cnt),   64'(7));
        check_val("sat_ctrl",   64'(s_ctrl_cnt), 64'(3));
        check_val("sat_mis",    64'(s_mis_cnt),  64'(3));

        // async reset between edges with both stages valid and an update pending
        fetch(32'hA00, 32'hA04); step();
        fetch(32'hA04, 32'hA08); ex_in(1'b1, 32'h0); step();
        fetch(32'hA08, 32'hA0C); ex_in(1'b1, 32'hA04); step();
        if_valid = 1'b0; ex_in(1'b1, 32'hB00); #1;
        check_val("ar_pre_upd",   64'(upd),   64'(1));
        check_val("ar_pre_flush", 64'(flush), 64'(1));
        #1 rst = 1'b1;
        #1;
        check_val("ar_flush",    64'(flush),      64'(0));
        check_val("ar_redirect", 64'(redirect),   64'(0));
        check_val("ar_upd",      64'(upd),        64'(0));
        check_val("ar_bia",      64'(bia),        64'(0));
        check_val("ar_ctrl",     64'(ctrl_cnt),   64'(0));
        check_val("ar_mis",      64'(mis_cnt),    64'(0));
        check_val("ar_sat_ctrl", 64'(s_ctrl_cnt), 64'(0));
        #1 rst = 1'b0;
        #1;
        check_val("ar_ex_gone", 64'(flush), 64'(0));
        step();
        check_val("ar_no_upd1", 64'(upd),      64'(0));
        check_val("ar_ctrl0",   64'(ctrl_cnt), 64'(0));
        check_val("ar_id_gone", 64'(flush),    64'(0));
        step();
        check_val("ar_no_upd2", 64'(upd),     64'(0));
        check_val("ar_mis0",    64'(mis_cnt), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Producer side of the branch predictor's update interface.
- Carries each fetched instruction's PC and predicted next PC through IF/ID and ID/EX alongside the pipeline.
- At EX, compares the prediction against the resolved next PC, drives the predictor update signals (registered), and raises a same-cycle flush/redirect on mispredict.
- Keeps saturating statistics counters for control instructions and mispredicts.

Parameters:
- XLEN, 32, PC and target width.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch issues an instruction this cycle
- if_pc  in  XLEN  PC of the fetched instruction
- if_predicted_pc  in  XLEN  predictor output for if_pc
- id_stall  in  1  load-use hazard: IF/ID holds, bubble enters ID/EX
- ex_is_ctrl  in  1  EX instruction is a branch, jal or jalr
- ex_actual_next_pc  in  XLEN  resolved next PC of the EX instruction (pc+4 for non-control)
- flush  out  1  combinational: squash IF/ID and ID/EX this edge
- redirect_pc  out  XLEN  combinational: fetch PC after a flush
- update_pred  out  1  registered predictor update strobe
- branch_inst_address  out  XLEN  registered PC being trained
- resolved_next_pc  out  XLEN  registered actual next PC
- predictor_wrong  out  1  registered mispredict flag for the update
- ctrl_count  out  CNT_W  resolved control instructions
- mispredict_count  out  CNT_W  resolved mispredicts

Behaviour:
- State: two stage records, S_ID and S_EX, each holding {valid, pc, pred}.
- Reset (async, takes effect immediately):
  - all valid bits 0, all update outputs 0, both counters 0;
  - flush = 0 and redirect_pc = 0, because S_EX.valid is 0.
  - Reset asserted mid-operation discards all in-flight records, and no update is emitted for them.
- wrong = S_EX.valid & (S_EX.pred != ex_actual_next_pc). The comparison is full XLEN.
- flush = wrong. redirect_pc = ex_actual_next_pc when wrong, else 0.
- Stage advance at each posedge, in priority order:
  - flush: S_ID.valid <= 0, S_EX.valid <= 0. An if_valid in the same cycle is wrong-path and is dropped. Flush beats id_stall.
  - id_stall: S_ID holds, S_EX.valid <= 0 (bubble).
  - otherwise: S_EX <= S_ID; S_ID <= {if_valid, if_pc, if_predicted_pc}.
- Update outputs, one cycle after EX resolution:
  - update_pred <= S_EX.valid & (ex_is_ctrl | wrong). A non-control instruction only produces an update when a BTB alias mispredicted it; it then trains not-taken.
  - When the update fires: branch_inst_address <= S_EX.pc, resolved_next_pc <= ex_actual_next_pc, predictor_wrong <= wrong.
  - When it does not fire: update_pred <= 0 and the other three fields hold their values.
  - update_pred is a single-cycle pulse per resolved instruction. Back-to-back EX instructions give back-to-back pulses.
- Counters:
  - ctrl_count += 1 when S_EX.valid & ex_is_ctrl.
  - mispredict_count += 1 when wrong.
  - Both saturate at all-ones and never wrap.
- Arithmetic: PC math is modulo 2^XLEN, so pc 0xFFFFFFFC + 4 = 0x0. The block itself never adds; it only compares.
- ex_is_ctrl and ex_actual_next_pc are ignored when S_EX.valid = 0.

Decomposition:
- Shared include branchresolver_def.v:
  - stage record field widths and ordering (valid, pc, pred);
  - CNT_W default;
  - the XLEN default, shared with the predictor's BHSR macros.
- One sub-module, pred_stage_reg: one record register with load, hold and clear inputs. Instantiated twice (ID, EX).
- Flush logic and the update register stay in the top.

Test Plan:
- Correct not-taken: if_pc=0x100, pred=0x104, no stall, actual=0x104, ctrl=1.
  - Required: 2 cycles later flush=0; next cycle update_pred=1, branch_inst_address=0x100, resolved_next_pc=0x104, predictor_wrong=0; ctrl_count=1.
- Taken mispredict: pc=0x200, pred=0x204, actual=0x180, with if_valid=1 in the flush cycle.
  - Required: flush=1 and redirect_pc=0x180 in the EX cycle; both stages invalid after the edge.
  - Required: next cycle update_pred=1, predictor_wrong=1; mispredict_count=1.
  - Required: the dropped fetch never produces an update.
- Stall: fetch 0x300 then id_stall=1 for 2 cycles.
  - Required: two bubbles in EX (no update, flush=0), then 0x300 resolves exactly once.
- Flush vs stall: wrong=1 together with id_stall=1.
  - Required: flush wins; both stages invalid next cycle.
- BTB alias on a non-control instruction: pc=0x400, pred=0x800, ctrl=0, actual=0x404.
  - Required: flush=1, redirect_pc=0x404, update_pred=1, predictor_wrong=1; ctrl_count unchanged.
- Async reset pulse between clock edges while both stages are valid.
  - Required: valids, update_pred and both counters read 0 before the next posedge.
  - Required: counters preloaded to all-ones via force stay saturated on further events.
